// File: rtl/prio_encoder_rr_pkg.sv
// ----------------------------------------------------------------------------
// prio_encoder_pkg
// Shared definitions for the priority encoder slice:
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   occ_state_t          : occupancy of the single output stage (EMPTY/FULL)
// ----------------------------------------------------------------------------
package prio_encoder_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } occ_state_t;

endpackage : prio_encoder_pkg

// File: rtl/prio_encoder_rr_if.sv
// ----------------------------------------------------------------------------
// prio_encoder_rr_if
// Handshake bundle around the priority encoder.
//   mode, in_req, in_valid, in_ready        : request side
//   out_idx, out_zero, out_multi,
//   out_valid, out_ready                    : result side
// Modport slave is the encoder itself. Modport master is the environment,
// which drives the requests and the downstream ready.
// ----------------------------------------------------------------------------
interface prio_encoder_rr_if #(
   parameter int N = 8
);
   localparam int W = $clog2(N);

   logic          mode;
   logic [N-1:0]  in_req;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_idx;
   logic          out_zero;
   logic          out_multi;
   logic          out_valid;
   logic          out_ready;

   modport slave (
      input  mode, in_req, in_valid, out_ready,
      output in_ready, out_idx, out_zero, out_multi, out_valid
   );

   modport master (
      output mode, in_req, in_valid, out_ready,
      input  in_ready, out_idx, out_zero, out_multi, out_valid
   );

endinterface : prio_encoder_rr_if

// File: rtl/prio_encoder_rr_find.sv
// ----------------------------------------------------------------------------
// prio_find_first
// Combinational circular search for the first set bit of vec, walking
// downward from index start and wrapping from 0 to N-1.
//   vec   [N] : request vector
//   start [W] : first index examined (highest priority)
//   idx   [W] : winning index (0 when nothing is set)
//   found     : at least one bit of vec is set
// With start = N-1 this is a plain MSB-first priority encoder.
// ----------------------------------------------------------------------------
module prio_find_first #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [W-1:0] idx_s;
   logic         found_s;

   // Circular search; walking from the lowest to the highest priority step
   // lets the highest-priority hit overwrite all later ones.
   always_comb begin
      idx_s   = {W{1'b0}};
      found_s = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         int pos;
         pos     = (int'(start) + N - i) % N;
         idx_s   = vec[pos] ? W'(pos) : idx_s;
         found_s = found_s | vec[pos];
      end
   end

   assign idx   = idx_s;
   assign found = found_s;

endmodule : prio_find_first

// File: rtl/prio_encoder_rr.sv
// ----------------------------------------------------------------------------
// prio_encoder_rr
// N-input priority encoder with one registered output stage and valid/ready
// on both sides. Fixed mode: highest set index wins. Round-robin mode: a
// rotating pointer marks the highest-priority index and moves just below each
// winner, giving every requester fair service.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (wins over any accept)
//   bus  : prio_encoder_rr_if.slave (requests in, encoded word out)
// in_ready is combinational (!out_valid || out_ready); there is no skid
// buffer, so a full stage accepts only when the held word retires that cycle.
// ----------------------------------------------------------------------------
module prio_encoder_rr
   import prio_encoder_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                rst,
   prio_encoder_rr_if.slave    bus
);

   localparam int W = $clog2(N);
   localparam logic [W-1:0] PTR_TOP = W'(N - 1);

   occ_state_t   state_r;
   occ_state_t   state_next_s;
   logic [W-1:0] ptr_r;
   logic [W-1:0] out_idx_r;
   logic         out_zero_r;
   logic         out_multi_r;

   logic         in_ready_s;
   logic         accept_s;
   logic [W-1:0] start_s;
   logic [W-1:0] win_idx_s;
   logic         found_s;
   logic         multi_s;

   assign in_ready_s = (state_r == ST_EMPTY) || bus.out_ready;
   assign accept_s   = bus.in_valid && in_ready_s;

   // Fixed mode always starts the search at the MSB; the pointer is only
   // consulted in round-robin mode and is left untouched otherwise.
   assign start_s = (bus.mode == MODE_RR) ? ptr_r : PTR_TOP;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_s = ((bus.in_req & (bus.in_req - N'(1))) != {N{1'b0}});

   prio_find_first #(
      .N (N),
      .W (W)
   ) u_find (
      .vec   (bus.in_req),
      .start (start_s),
      .idx   (win_idx_s),
      .found (found_s)
   );

   // Output-stage occupancy register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Occupancy next state: an accept always fills the stage (including
   // back-to-back with a retire); otherwise a retire empties it.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               state_next_s = ST_FULL;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (accept_s) begin
               state_next_s = ST_FULL;
            end else if (bus.out_ready) begin
               state_next_s = ST_EMPTY;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         default: begin
            state_next_s = ST_EMPTY;
         end
      endcase
   end

   // Output word register; loads on accept, holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_idx_r   <= {W{1'b0}};
         out_zero_r  <= 1'b0;
         out_multi_r <= 1'b0;
      end else if (accept_s) begin
         out_idx_r   <= found_s ? win_idx_s : {W{1'b0}};
         out_zero_r  <= ~found_s;
         out_multi_r <= multi_s;
      end else begin
         out_idx_r   <= out_idx_r;
         out_zero_r  <= out_zero_r;
         out_multi_r <= out_multi_r;
      end
   end

   // Round-robin pointer: after a win at k the next search starts at k-1,
   // wrapping to N-1. All-zero vectors and fixed-mode accepts leave it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= PTR_TOP;
      end else if (accept_s && found_s && (bus.mode == MODE_RR)) begin
         ptr_r <= (win_idx_s == {W{1'b0}}) ? PTR_TOP : (win_idx_s - W'(1));
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = (state_r == ST_FULL);
   assign bus.out_idx   = out_idx_r;
   assign bus.out_zero  = out_zero_r;
   assign bus.out_multi = out_multi_r;

endmodule : prio_encoder_rr

// File: tb/tb_prio_encoder_rr.sv
// ----------------------------------------------------------------------------
// tb_prio_encoder_rr
// Directed scenarios followed by random traffic. The driver predicts each
// accepted word from a reference model and queues it; an independent monitor
// compares every word the DUT hands downstream against the queue head.
// ----------------------------------------------------------------------------
module tb_prio_encoder_rr;

   localparam int N = 8;

   typedef struct packed {
      logic [2:0] idx;
      logic       zero;
      logic       multi;
   } exp_t;

   logic clk;
   logic rst;

   prio_encoder_rr_if #(.N(N)) bus ();

   prio_encoder_rr #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   tests;
   int   fails;
   int   m_ptr;

   // Reference prediction: straight from the priority rules.
   task automatic predict(input logic [7:0] r, input logic m, output exp_t e);
      e.idx   = 3'd0;
      e.zero  = (r == 8'h00);
      e.multi = ($countones(r) > 1);
      if (r != 8'h00) begin
         if (m == 1'b0) begin
            for (int k = 7; k >= 0; k--) begin
               if (r[k]) begin
                  e.idx = 3'(k);
                  break;
               end
            end
         end else begin
            for (int k = 0; k < 8; k++) begin
               int p;
               p = (m_ptr - k + 8) % 8;
               if (r[p]) begin
                  e.idx = 3'(p);
                  m_ptr = (p == 0) ? 7 : p - 1;
                  break;
               end
            end
         end
      end
   endtask

   // One clock of stimulus; inputs change 1 time unit after the rising edge.
   task automatic step(input logic v, input logic [7:0] r, input logic m,
                       input logic rdy, input logic rs);
      exp_t e;
      bus.in_valid  = v;
      bus.in_req    = r;
      bus.mode      = m;
      bus.out_ready = rdy;
      rst           = rs;
      @(negedge clk);
      if (rs) begin
         exp_q.delete();
         m_ptr = 7;
      end else if (v && bus.in_ready) begin
         predict(r, m, e);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_idx !== 3'd0 ||
          bus.out_zero !== 1'b0 || bus.out_multi !== 1'b0) begin
         fails++;
         $display("FAIL %s: got valid=%b idx=%0d zero=%b multi=%b, want all 0",
                  name, bus.out_valid, bus.out_idx, bus.out_zero, bus.out_multi);
      end
   endtask

   // Monitor: handshake rule, held-word stability, and scoreboard pops.
   initial begin : monitor
      exp_t got;
      exp_t held;
      exp_t want;
      logic stalled;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         got = {bus.out_idx, bus.out_zero, bus.out_multi};
         if (!rst) begin
            tests++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
               fails++;
               $display("FAIL in_ready: got %b, want %b", bus.in_ready,
                        (!bus.out_valid || bus.out_ready));
            end
            if (stalled && bus.out_valid) begin
               tests++;
               if (got !== held) begin
                  fails++;
                  $display("FAIL hold: word changed under backpressure, got %h want %h",
                           got, held);
               end
            end
            if (bus.out_valid && bus.out_ready) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_word: got idx=%0d zero=%b multi=%b, want none",
                           bus.out_idx, bus.out_zero, bus.out_multi);
               end else begin
                  want = exp_q.pop_front();
                  if (got !== want) begin
                     fails++;
                     $display("FAIL word: got idx=%0d zero=%b multi=%b, want idx=%0d zero=%b multi=%b",
                              got.idx, got.zero, got.multi, want.idx, want.zero, want.multi);
                  end
               end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = got;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin : driver
      tests = 0;
      fails = 0;
      m_ptr = 7;
      bus.in_valid  = 1'b0;
      bus.in_req    = 8'h00;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_idle("reset_state");

      // 1. fixed mode one-hot sweep, then all-zero
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, 8'h01 << i, 1'b0, 1'b1, 1'b0);
      end
      step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

      // 2. fixed mode, several bits set
      step(1'b1, 8'b0101_0010, 1'b0, 1'b1, 1'b0);

      // 3. round-robin, all requesting, wraps after 8 accepts
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
      end

      // 4. round-robin alternating pair, mode switch mid-stream and back
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'b0000_1001, 1'b1, 1'b1, 1'b0);
      end
      step(1'b1, 8'b0000_1001, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'b0000_1001, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'b0000_1001, 1'b1, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // 5. backpressure: stage fills, three stalled cycles, then release
      step(1'b1, 8'b0110_0000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
      tests++;
      if (bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL back_to_back: got out_valid=%b, want 1", bus.out_valid);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // 6. reset while a word is held and the pointer sits at 2
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
      end
      step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_idle("reset_mid_op");
      step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      check_idle("reset_beats_accept");
      step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] r;
         case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'h01 << $urandom_range(0, 7);
            default: r = 8'($urandom);
         endcase
         step(1'($urandom_range(0, 3) != 0), r, 1'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
      end

      // drain and confirm nothing predicted was lost
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d words never delivered, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_prio_encoder_rr
